fetch_unit: RTL and testbench

Instruction fetch front end placed between the PC stage and the IF/ID boundary. It takes the current PC, issues in-order requests to the instruction memory over a request/grant/response handshake, and buffers returned instructions with their PCs in a small in-order queue. Decode consumes the queue through a valid/ready handshake. The block tells the PC stage when to advance, and it discards in-flight and buffered work on a control-flow flush.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional misalignment check: FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

  localparam int DEPTH_DEF = 2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: reserve at tail, fill oldest unfilled,
// pop at head, clear on redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         rsv,
  input  logic [31:0]  rsv_pc,
  input  logic         rsv_pre,
  input  logic         fill,
  input  logic [31:0]  fill_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      ent_q [DEPTH];
  fetch_entry_t      ent_d [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW:0]       cnt_q, cnt_d;
  logic [PW-1:0]     fl_ptr;
  logic              fl_hit;

  // Fill pointer: oldest reserved entry still waiting for memory.
  always_comb begin
    fl_ptr = rd_q;
    fl_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fl_hit && ((PW+1)'(i) < cnt_q) &&
          !ent_q[rd_q + PW'(i)].filled) begin
        fl_ptr = rd_q + PW'(i);
        fl_hit = 1'b1;
      end
    end
  end

  // Next state: clear wins, otherwise fill, pop and reserve together.
  always_comb begin
    ent_d = ent_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (fill && fl_hit) begin
        ent_d[fl_ptr].instr  = fill_data;
        ent_d[fl_ptr].filled = 1'b1;
      end
      if (pop) rd_d = rd_q + PW'(1);
      if (rsv) begin
        ent_d[wr_q] = '{pc:       rsv_pc,
                        instr:    rsv_pre ? NOP_INSTR : 32'h0,
                        filled:   rsv_pre,
                        misalign: rsv_pre};
        wr_d = wr_q + PW'(1);
      end
      cnt_d = cnt_q + (PW+1)'(rsv) - (PW+1)'(pop);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head       = ent_q[rd_q];
  assign head_valid = (cnt_q != '0) && ent_q[rd_q].filled;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: memory handshake, credit and kill accounting.
// Optional misalignment check: FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        id_misalign
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          started_q, started_d;
  logic [CW-1:0] alloc_q, alloc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] out_q, out_d;

  logic          credit;
  logic          mis;
  logic          mgrant;
  logic          rsp_any;
  logic          dropping;
  logic          fill;
  logic          pop;
  fetch_entry_t  head;
  logic          head_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign mis = |pc_in[1:0];
`else
  assign mis = 1'b0;
`endif

  assign credit = started_q & ~flush &
                  (({1'b0, alloc_q} + {1'b0, drop_q})
                   < (CW+1)'(DEPTH));

  assign imem_req   = credit & ~mis;
  assign imem_addr  = {pc_in[31:2], 2'b00};
  assign pc_advance = credit & (mis | imem_gnt);
  assign mgrant     = imem_req & imem_gnt;

  assign rsp_any  = imem_rvalid &
                    ((drop_q != '0) | (out_q != '0));
  assign dropping = imem_rvalid & (drop_q != '0);
  assign fill     = imem_rvalid & (drop_q == '0) &
                    (out_q != '0) & ~flush;
  assign pop      = head_valid & id_ready & ~flush;

  // Credit, outstanding and kill counters; flush moves
  // outstanding requests into the drop count.
  always_comb begin
    started_d = 1'b1;
    alloc_d   = alloc_q;
    drop_d    = drop_q;
    out_d     = out_q;
    if (flush) begin
      alloc_d = '0;
      out_d   = '0;
      drop_d  = drop_q + out_q - CW'(rsp_any);
    end else begin
      alloc_d = alloc_q + CW'(pc_advance) - CW'(pop);
      out_d   = out_q + CW'(mgrant) - CW'(fill);
      drop_d  = drop_q - CW'(dropping);
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q <= 1'b0;
      alloc_q   <= '0;
      drop_q    <= '0;
      out_q     <= '0;
    end else begin
      started_q <= started_d;
      alloc_q   <= alloc_d;
      drop_q    <= drop_d;
      out_q     <= out_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (flush),
    .rsv        (pc_advance),
    .rsv_pc     (pc_in),
    .rsv_pre    (mis),
    .fill       (fill),
    .fill_data  (imem_rdata),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid)
  );

  assign id_valid = head_valid;
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign id_misalign = head.misalign;
`else
  logic unused_mis;
  assign unused_mis = head.misalign;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order memory model.
// Define FETCH_ALIGN_CHECK_EN to also cover the misalignment path.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = '0;
  logic        pc_advance;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_misalign;
`endif

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .id_misalign (id_misalign)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mrsp_t;

  exp_t  expq [$];
  mrsp_t memq [$];

  int nchk = 0;
  int npass = 0;
  int lat = 1;
  int gcyc = 0;
  int first_pop_cyc = -1;
  bit lat_arm = 1'b0;
  int mout = 0;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BD0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chkb(input string nm, input logic act,
                      input logic exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic expect_pc(input logic [31:0] pc, input logic mis);
    exp_t e;
    e.pc    = pc;
    e.instr = mis ? NOP_INSTR : mdata(pc);
    e.mis   = mis;
    expq.push_back(e);
  endtask

  // Memory: records grants mid-cycle, answers lat cycles later.
  initial begin
    mrsp_t r;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        r.due  = cyc + lat;
        r.addr = imem_addr;
        memq.push_back(r);
      end
      @(posedge clk);
      #1;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mdata(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
  end

  // Monitor: pops the scoreboard on every decode handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (imem_rvalid) begin
        assert (mout > 0)
          else $error("rvalid with no request outstanding");
        mout--;
      end
      if (imem_req && imem_gnt) mout++;
      if (reset && id_valid && id_ready && !flush) begin
        if (expq.size() == 0) begin
          nchk++;
          $display("FAIL unexpected_pop: got pc %h want none",
                   id_pc);
        end else begin
          e = expq.pop_front();
          chk("pop_pc", id_pc, e.pc);
          chk("pop_instr", id_instr, e.instr);
`ifdef FETCH_ALIGN_CHECK_EN
          chkb("pop_mis", id_misalign, e.mis);
`endif
          if (lat_arm) begin
            first_pop_cyc = cyc;
            lat_arm = 1'b0;
          end
        end
      end
    end
  end

  task automatic feed(input logic [31:0] base, input int n);
    int k = 0;
    int t = 0;
    pc_in    = base;
    imem_gnt = 1'b1;
    while (k < n && t < 200) begin
      @(negedge clk);
      if (pc_advance) begin
        if (k == 0) gcyc = cyc;
        k++;
      end
      @(posedge clk);
      #1;
      pc_in = base + 32'(4 * k);
      t++;
    end
    imem_gnt = 1'b0;
    nchk++;
    if (k == n) npass++;
    else $display("FAIL feed_timeout: got %0d grants want %0d", k, n);
  endtask

  task automatic drain();
    int t = 0;
    while ((expq.size() != 0 || memq.size() != 0) && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    nchk++;
    if (expq.size() == 0 && memq.size() == 0) npass++;
    else $display("FAIL drain_timeout: got %0d left want 0",
                  expq.size());
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chkb("rst_req", imem_req, 1'b0);
    chkb("rst_adv", pc_advance, 1'b0);
    chkb("rst_valid", id_valid, 1'b0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chkb("start_req", imem_req, 1'b0);

    // in-order stream
    id_ready = 1'b1;
    lat = 1;
    expect_pc(32'h0, 1'b0);
    expect_pc(32'h4, 1'b0);
    expect_pc(32'h8, 1'b0);
    lat_arm = 1'b1;
    feed(32'h0, 3);
    drain();
    chk("first_lat", 32'(first_pop_cyc), 32'(gcyc + 2));

    // grant wait
    pc_in = 32'h100;
    expect_pc(32'h100, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chkb("hold_req", imem_req, 1'b1);
      chk("hold_addr", imem_addr, 32'h100);
      chkb("hold_adv", pc_advance, 1'b0);
    end
    @(posedge clk);
    #1;
    feed(32'h100, 1);
    drain();

    // decode backpressure
    id_ready = 1'b0;
    expect_pc(32'h300, 1'b0);
    expect_pc(32'h304, 1'b0);
    expect_pc(32'h308, 1'b0);
    feed(32'h300, 2);
    imem_gnt = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chkb("bp_req", imem_req, 1'b0);
    end
    @(posedge clk);
    #1;
    id_ready = 1'b1;
    @(negedge clk);
    chkb("bp_valid", id_valid, 1'b1);
    chkb("bp_req_pop", imem_req, 1'b0);
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    @(negedge clk);
    chkb("bp_req_again", imem_req, 1'b1);
    chkb("bp_adv", pc_advance, 1'b1);
    @(posedge clk);
    #1;
    imem_gnt = 1'b0;
    id_ready = 1'b1;
    drain();

    // flush with two requests in flight
    lat = 3;
    feed(32'h500, 2);
    flush = 1'b1;
    @(negedge clk);
    chkb("fl_req", imem_req, 1'b0);
    chkb("fl_adv", pc_advance, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc_in = 32'h200;
    @(negedge clk);
    chkb("fl_valid", id_valid, 1'b0);
    chkb("fl_credit", imem_req, 1'b0);
    @(posedge clk);
    #1;
    expect_pc(32'h200, 1'b0);
    expect_pc(32'h204, 1'b0);
    feed(32'h200, 2);
    drain();

    // flush together with a fill and a pop
    lat = 1;
    feed(32'h700, 2);
    flush = 1'b1;
    @(negedge clk);
    chkb("f5_valid", id_valid, 1'b1);
    chkb("f5_rvalid", imem_rvalid, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    pc_in = 32'h600;
    @(negedge clk);
    chkb("f5_empty", id_valid, 1'b0);
    chkb("f5_credit", imem_req, 1'b1);
    @(posedge clk);
    #1;
    expect_pc(32'h600, 1'b0);
    feed(32'h600, 1);
    drain();

`ifdef FETCH_ALIGN_CHECK_EN
    // misaligned PC behind an older slow fetch
    lat = 2;
    expect_pc(32'h1F8, 1'b0);
    expect_pc(32'h202, 1'b1);
    feed(32'h1F8, 1);
    pc_in    = 32'h202;
    imem_gnt = 1'b1;
    @(negedge clk);
    chkb("mis_req", imem_req, 1'b0);
    chkb("mis_adv", pc_advance, 1'b1);
    chkb("mis_order", id_valid, 1'b0);
    @(posedge clk);
    #1;
    pc_in    = 32'h210;
    imem_gnt = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
